pwm_reg_arbiter: RTL and testbench

Owns the five PWM configuration registers: output enable low/high, PWM enable low/high, and duty cycle. It arbitrates register writes from two requesters: port A, the SPI write decoder, and port B, an on-chip sequencer. It holds the accepted values in shadow registers and commits them to the live outputs only at a PWM period boundary, so the PWM generator never sees a partially updated configuration mid-period.

---
 rtl/pwm_cfg_pkg.sv | 10 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/pwm_reg_arbiter.sv | 97 +++++++++
 tb/tb_pwm_reg_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg: shared register map and requester identifiers for PWM configuration blocks
package pwm_cfg_pkg;
  localparam int NUM_REGS    = 5;
  localparam int ADDR_OUT_LO = 0;
  localparam int ADDR_OUT_HI = 1;
  localparam int ADDR_PWM_LO = 2;
  localparam int ADDR_PWM_HI = 3;
  localparam int ADDR_DUTY   = 4;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter with a one-bit last-grant register
//   clk, rst         : clock, synchronous active-high reset (last grant resets to B)
//   req_a, req_b     : requests
//   gnt_a, gnt_b     : combinational one-hot grants, both low while rst is high
module rr_arbiter2
  import pwm_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  port_e last_grant_q, last_grant_d;
  always_comb begin
    gnt_a = !rst && req_a && (!req_b || last_grant_q == PORT_B);
    gnt_b = !rst && req_b && !gnt_a;
    last_grant_d = gnt_a ? PORT_A : gnt_b ? PORT_B : last_grant_q;
  end
  always_ff @(posedge clk)
    last_grant_q <= rst ? PORT_B : last_grant_d;
endmodule

// File: rtl/pwm_reg_arbiter.sv
// pwm_reg_arbiter: arbitrates two register writers and commits PWM config at period boundaries
//   clk, rst                 : clock, synchronous active-high reset
//   a_valid/a_addr/a_data    : port A (SPI decoder) write request, a_ready = accepted
//   b_valid/b_addr/b_data    : port B (sequencer) write request, b_ready = accepted
//   period_end               : last count of the PWM period; commits dirty shadows
//   en_reg_*, pwm_duty_cycle : live configuration
//   update_pending           : some shadow differs from live
//   wr_err                   : pulse the cycle after an accepted out-of-range write
//   PWM_SHADOW_EN            : when defined, writes go through shadows; otherwise straight to live
module pwm_reg_arbiter
  import pwm_cfg_pkg::*;
#(
  parameter logic [6:0] MAX_ADDRESS = 7'h04
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       period_end,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       update_pending,
  output logic       wr_err
);
  logic                wr, err, wr_err_q;
  logic [6:0]          addr;
  logic [7:0]          data;
  logic [NUM_REGS-1:0] wsel;
  logic [7:0]          live_q [NUM_REGS];
  logic [7:0]          live_d [NUM_REGS];
  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (a_ready),
    .gnt_b (b_ready)
  );
  always_comb begin
    wr   = a_ready | b_ready;
    addr = a_ready ? a_addr : b_addr;
    data = a_ready ? a_data : b_data;
    err  = wr && addr > MAX_ADDRESS;
    for (int i = 0; i < NUM_REGS; i++) wsel[i] = wr && !err && addr == 7'(i);
  end
`ifdef PWM_SHADOW_EN
  logic [7:0]          shad_q [NUM_REGS];
  logic [7:0]          shad_d [NUM_REGS];
  logic [NUM_REGS-1:0] mask_q, mask_d;
  // commit reads the pre-write shadow, so a write in the commit cycle stays pending
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      shad_d[i] = wsel[i] ? data : shad_q[i];
      live_d[i] = period_end && mask_q[i] ? shad_q[i] : live_q[i];
    end
    mask_d = period_end ? wsel : mask_q | wsel;
  end
  always_ff @(posedge clk)
    if (rst) begin
      shad_q <= '{default: '0};
      mask_q <= '0;
    end else begin
      shad_q <= shad_d;
      mask_q <= mask_d;
    end
  assign update_pending = |mask_q;
`else
  logic unused_period_end;
  assign unused_period_end = period_end;
  always_comb
    for (int i = 0; i < NUM_REGS; i++) live_d[i] = wsel[i] ? data : live_q[i];
  assign update_pending = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      live_q   <= '{default: '0};
      wr_err_q <= 1'b0;
    end else begin
      live_q   <= live_d;
      wr_err_q <= err;
    end
  assign wr_err          = wr_err_q;
  assign en_reg_out_7_0  = live_q[ADDR_OUT_LO];
  assign en_reg_out_15_8 = live_q[ADDR_OUT_HI];
  assign en_reg_pwm_7_0  = live_q[ADDR_PWM_LO];
  assign en_reg_pwm_15_8 = live_q[ADDR_PWM_HI];
  assign pwm_duty_cycle  = live_q[ADDR_DUTY];
endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// tb_pwm_reg_arbiter: directed and random writes checked against a register-map model
module tb_pwm_reg_arbiter;
  logic       clk = 1'b0;
  logic       rst, a_valid, b_valid, period_end;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, update_pending, wr_err;
  logic [7:0] dut_live [5];
  int         total = 0, bad = 0;
  logic [7:0] m_live [5];
  logic [7:0] m_shad [5];
  bit         m_dirty [5];
  bit         m_last_b, m_err, ga, gb;
  always #5 clk = ~clk;
  pwm_reg_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .a_valid         (a_valid),
    .a_addr          (a_addr),
    .a_data          (a_data),
    .a_ready         (a_ready),
    .b_valid         (b_valid),
    .b_addr          (b_addr),
    .b_data          (b_data),
    .b_ready         (b_ready),
    .period_end      (period_end),
    .en_reg_out_7_0  (dut_live[0]),
    .en_reg_out_15_8 (dut_live[1]),
    .en_reg_pwm_7_0  (dut_live[2]),
    .en_reg_pwm_15_8 (dut_live[3]),
    .pwm_duty_cycle  (dut_live[4]),
    .update_pending  (update_pending),
    .wr_err          (wr_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_live[i]  = 8'h00;
      m_shad[i]  = 8'h00;
      m_dirty[i] = 1'b0;
    end
    m_last_b = 1'b1;
    m_err    = 1'b0;
  endtask
  function automatic bit any_dirty();
    bit r = 1'b0;
    for (int i = 0; i < 5; i++) r |= m_dirty[i];
    return r;
  endfunction
  task automatic cycle();
    bit         g;
    logic [6:0] ad;
    logic [7:0] d;
    @(negedge clk);
    ga = !rst && a_valid && (!b_valid || m_last_b);
    gb = !rst && b_valid && !ga;
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("wr_err", wr_err, m_err);
`ifdef PWM_SHADOW_EN
    check("update_pending", update_pending, any_dirty());
`else
    check("update_pending", update_pending, 0);
`endif
    for (int i = 0; i < 5; i++) check($sformatf("live%0d", i), dut_live[i], m_live[i]);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      g  = ga || gb;
      ad = ga ? a_addr : b_addr;
      d  = ga ? a_data : b_data;
      if (g) m_last_b = gb;
      m_err = g && ad > 7'd4;
`ifdef PWM_SHADOW_EN
      if (period_end)
        for (int i = 0; i < 5; i++)
          if (m_dirty[i]) begin
            m_live[i]  = m_shad[i];
            m_dirty[i] = 1'b0;
          end
      if (g && ad <= 7'd4) begin
        m_shad[ad]  = d;
        m_dirty[ad] = 1'b1;
      end
`else
      if (g && ad <= 7'd4) m_live[ad] = d;
`endif
    end
    #1;
  endtask
  task automatic set_a(input logic [6:0] ad, input logic [7:0] d);
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
  endtask
  task automatic set_b(input logic [6:0] ad, input logic [7:0] d);
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
  endtask
  task automatic pulse_pe();
    period_end = 1'b1;
    cycle();
    period_end = 1'b0;
    cycle();
  endtask
  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; period_end = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    set_a(7'd4, 8'h80);
    cycle();
    a_valid = 1'b0;
    cycle();
    pulse_pe();
    set_a(7'd0, 8'hAA);
    set_b(7'd0, 8'h55);
    for (int k = 0; k < 4 && (a_valid || b_valid); k++) begin
      cycle();
      if (ga) a_valid = 1'b0;
      if (gb) b_valid = 1'b0;
    end
    check("tie_drained", {a_valid, b_valid}, 0);
    cycle();
    pulse_pe();
    set_a(7'd2, 8'h0F);
    cycle();
    a_valid = 1'b0;
    cycle();
    set_a(7'd2, 8'hF0);
    period_end = 1'b1;
    cycle();
    a_valid = 1'b0;
    period_end = 1'b0;
    cycle();
    pulse_pe();
    set_a(7'h05, 8'h12);
    cycle();
    a_valid = 1'b0;
    check("oor_wr_err", wr_err, 1);
    cycle();
    cycle();
    set_a(7'd0, 8'h11); cycle();
    set_a(7'd1, 8'h22); cycle();
    set_a(7'd3, 8'h33); cycle();
    a_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    pulse_pe();
    set_b(7'd1, 8'h3C);
    cycle();
    b_valid = 1'b0;
`ifndef PWM_SHADOW_EN
    check("direct_out_hi", dut_live[1], 8'h3C);
`endif
    cycle();
    pulse_pe();
    for (int n = 0; n < 3000; n++) begin
      if (!a_valid && $urandom_range(0, 2) == 0)
        set_a($urandom_range(0, 7) == 0 ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4)), 8'($urandom));
      if (!b_valid && $urandom_range(0, 2) == 0)
        set_b($urandom_range(0, 7) == 0 ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4)), 8'($urandom));
      period_end = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 99) == 0;
      cycle();
      if (ga) a_valid = 1'b0;
      if (gb) b_valid = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
